execute_sequencer: RTL and testbench
====================================

Name: execute_sequencer

Overview:
Sequences the execute phase of the multicycle calculator core. It accepts one decoded 18-bit instruction over a valid/ready handshake and dispatches it to the ALU, the multiplier or the divider. For the multiplier and divider it runs a start/done handshake and bounds each wait with a timeout. It returns an 18-bit result plus an error flag over a valid/ready handshake, and sits between the decode stage and the writeback/memory stage.

Parameters:
OPERAND_WIDTH, 8, width of operands A and B.
RESULT_WIDTH, 18, width of instruction word and results.
TIMEOUT_CYCLES, 64, maximum number of WAIT cycles before a mul/div is aborted; must be >= 2.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept an instruction
instr  in  RESULT_WIDTH  instruction fields: [17] opcode (0 = ADDSUB, 1 = MULDIV); [16] funct (0 = ADD/MUL, 1 = SUB/DIV); [15:8] A; [7:0] B
alu_operation  out  1  0 = add, 1 = sub
alu_operand_1  out  OPERAND_WIDTH  ALU operand 1 (A)
alu_operand_2  out  OPERAND_WIDTH  ALU operand 2 (B)
alu_result  in  RESULT_WIDTH  combinational ALU result
mul_start  out  1  one-cycle start pulse to the multiplier
mul_operand_1  out  OPERAND_WIDTH  multiplier operand 1 (A)
mul_operand_2  out  OPERAND_WIDTH  multiplier operand 2 (B)
mul_done  in  1  product valid, single-cycle pulse
mul_product  in  RESULT_WIDTH  multiplier product
div_start  out  1  one-cycle start pulse to the divider
div_operand_1  out  OPERAND_WIDTH  dividend (A)
div_operand_2  out  OPERAND_WIDTH  divisor (B)
div_done  in  1  quotient valid, single-cycle pulse
div_result  in  RESULT_WIDTH  divider result
result_valid  out  1  result available
result_ready  in  1  consumer accepts the result
result  out  RESULT_WIDTH  registered result
result_error  out  1  divide-by-zero or timeout
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, WAIT_MUL, WAIT_DIV, RESP. Registers: opcode, funct, A, B, result, result_error, 8-bit timeout counter.
- Reset (synchronous) forces state = IDLE and clears result, result_error, the counter, mul_start and div_start.
  - While reset is high, instr_ready, result_valid and busy are 0.
  - reset takes priority over every other event in every state.
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready, latch the instruction fields and go to EXEC.
- EXEC (always exactly 1 cycle):
  - ADDSUB: alu_operation = funct, ALU operands = latched A and B; register alu_result into result with error = 0; go to RESP.
  - MUL: mul_start = 1 for this cycle only; clear the counter; go to WAIT_MUL.
  - DIV with B != 0: div_start = 1 for this cycle only; clear the counter; go to WAIT_DIV.
  - DIV with B == 0: no div_start; result = all ones (18'h3FFFF), error = 1; go to RESP.
- WAIT_MUL / WAIT_DIV:
  - The matching done captures its data with error = 0, then go to RESP.
  - Otherwise the counter increments. When the counter == TIMEOUT_CYCLES-1 without done: result = 0, error = 1, go to RESP.
  - done in the same cycle as the timeout: done wins.
  - The non-matching done is ignored.
- RESP:
  - result_valid = 1; result and result_error held stable until result_ready.
  - On result_ready go to IDLE. The next instruction can be accepted one cycle later (no same-cycle bypass).
- Operand outputs are driven continuously from the latched A/B registers; they are don't-care outside EXEC/WAIT.
  - alu_operation is 0 except in EXEC for SUB.
- instr_ready = 0 in every state except IDLE. mul_done and div_done are ignored outside their WAIT state.
- Latency, from the accept edge to result_valid high:
  - ADD/SUB: 2 cycles.
  - DIV by zero: 2 cycles.
  - MUL/DIV: 2 cycles + (cycles until done).
- Reset during WAIT_*: return to IDLE; a late done arriving afterwards has no effect.

Test Plan:
1. ADD, A = 200, B = 100, result_ready held 1 -> result = 300, error = 0, result_valid high 2 cycles after accept for exactly 1 cycle; instr_ready low throughout.
2. SUB, A = 50, B = 20 -> alu_operation = 1 during EXEC; result = 30, error = 0.
3. MUL, A = 12, B = 13; model returns mul_done with product 156 five cycles after start -> one-cycle mul_start with operands 12/13; result = 156.
4. DIV, A = 9, B = 0 -> div_start never asserted; result = 18'h3FFFF, error = 1.
5. DIV, A = 100, B = 7, model never responds -> after 64 WAIT cycles result = 0, error = 1. Rerun with div_done in the final wait cycle -> div_result is returned, error = 0.
6. result_ready held low 5 cycles in RESP -> result stable, instr_valid ignored. Separately, reset in WAIT_MUL followed by mul_done 2 cycles later -> state IDLE, no result_valid.

Source files
------------

// File: rtl/execute_sequencer.sv
// Execute-phase sequencer of the multicycle calculator core: dispatches one decoded
// instruction to the ALU, multiplier or divider and returns a registered result.
module execute_sequencer #(
    parameter int OPERAND_WIDTH  = 8,
    parameter int RESULT_WIDTH   = 18,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [RESULT_WIDTH-1:0]  instr,

    output logic                     alu_operation,
    output logic [OPERAND_WIDTH-1:0] alu_operand_1,
    output logic [OPERAND_WIDTH-1:0] alu_operand_2,
    input  logic [RESULT_WIDTH-1:0]  alu_result,

    output logic                     mul_start,
    output logic [OPERAND_WIDTH-1:0] mul_operand_1,
    output logic [OPERAND_WIDTH-1:0] mul_operand_2,
    input  logic                     mul_done,
    input  logic [RESULT_WIDTH-1:0]  mul_product,

    output logic                     div_start,
    output logic [OPERAND_WIDTH-1:0] div_operand_1,
    output logic [OPERAND_WIDTH-1:0] div_operand_2,
    input  logic                     div_done,
    input  logic [RESULT_WIDTH-1:0]  div_result,

    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [RESULT_WIDTH-1:0]  result,
    output logic                     result_error,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT_MUL,
        WAIT_DIV,
        RESP
    } stateType;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    stateType                 state;
    logic                     opcodeReg;
    logic                     functReg;
    logic [OPERAND_WIDTH-1:0] operandA;
    logic [OPERAND_WIDTH-1:0] operandB;
    logic [RESULT_WIDTH-1:0]  resultReg;
    logic                     resultErrorReg;
    logic [7:0]               timeoutCount;
    logic                     mulStartReg;
    logic                     divStartReg;
    logic                     aluSubReg;

    logic                     instrOpcode;
    logic                     instrFunct;
    logic [OPERAND_WIDTH-1:0] instrA;
    logic [OPERAND_WIDTH-1:0] instrB;
    logic                     waitDone;
    logic [RESULT_WIDTH-1:0]  waitData;

    assign instrOpcode = instr[RESULT_WIDTH-1];
    assign instrFunct  = instr[RESULT_WIDTH-2];
    assign instrA      = instr[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
    assign instrB      = instr[OPERAND_WIDTH-1:0];

    // Only the done belonging to the current wait state is ever looked at.
    always_comb begin
        waitDone = 1'b0;
        waitData = '0;
        if (state == WAIT_MUL) begin
            waitDone = mul_done;
            waitData = mul_product;
        end else if (state == WAIT_DIV) begin
            waitDone = div_done;
            waitData = div_result;
        end
    end

    // Start pulses and the subtract select are set on the accept edge so that
    // they are registered yet high exactly during the EXEC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            resultReg      <= '0;
            resultErrorReg <= 1'b0;
            timeoutCount   <= '0;
            mulStartReg    <= 1'b0;
            divStartReg    <= 1'b0;
            aluSubReg      <= 1'b0;
        end else begin
            mulStartReg <= 1'b0;
            divStartReg <= 1'b0;
            aluSubReg   <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        opcodeReg   <= instrOpcode;
                        functReg    <= instrFunct;
                        operandA    <= instrA;
                        operandB    <= instrB;
                        mulStartReg <= instrOpcode && !instrFunct;
                        divStartReg <= instrOpcode && instrFunct && (instrB != '0);
                        aluSubReg   <= !instrOpcode && instrFunct;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!opcodeReg) begin
                        resultReg      <= alu_result;
                        resultErrorReg <= 1'b0;
                        state          <= RESP;
                    end else if (!functReg) begin
                        timeoutCount <= '0;
                        state        <= WAIT_MUL;
                    end else if (operandB == '0) begin
                        resultReg      <= '1;
                        resultErrorReg <= 1'b1;
                        state          <= RESP;
                    end else begin
                        timeoutCount <= '0;
                        state        <= WAIT_DIV;
                    end
                end
                WAIT_MUL, WAIT_DIV: begin
                    if (waitDone) begin
                        resultReg      <= waitData;
                        resultErrorReg <= 1'b0;
                        state          <= RESP;
                    end else if (timeoutCount == TimeoutLast) begin
                        resultReg      <= '0;
                        resultErrorReg <= 1'b1;
                        state          <= RESP;
                    end else begin
                        timeoutCount <= timeoutCount + 8'd1;
                    end
                end
                RESP: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign instr_ready   = (state == IDLE) && !reset;
    assign result_valid  = (state == RESP) && !reset;
    assign busy          = (state != IDLE) && !reset;

    assign result        = resultReg;
    assign result_error  = resultErrorReg;

    assign alu_operation = aluSubReg;
    assign alu_operand_1 = operandA;
    assign alu_operand_2 = operandB;

    assign mul_start     = mulStartReg;
    assign mul_operand_1 = operandA;
    assign mul_operand_2 = operandB;

    assign div_start     = divStartReg;
    assign div_operand_1 = operandA;
    assign div_operand_2 = operandB;

endmodule

// File: tb/tb_execute_sequencer.sv
// Self-checking bench for execute_sequencer: directed vector table, reset corner
// cases and randomized instructions checked against a behavioural model.
module tb_execute_sequencer;

    localparam int OW = 8;
    localparam int RW = 18;
    localparam int TO = 64;

    logic          clk;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [RW-1:0] instr;
    logic          alu_operation;
    logic [OW-1:0] alu_operand_1;
    logic [OW-1:0] alu_operand_2;
    logic [RW-1:0] alu_result;
    logic          mul_start;
    logic [OW-1:0] mul_operand_1;
    logic [OW-1:0] mul_operand_2;
    logic          mul_done;
    logic [RW-1:0] mul_product;
    logic          div_start;
    logic [OW-1:0] div_operand_1;
    logic [OW-1:0] div_operand_2;
    logic          div_done;
    logic [RW-1:0] div_result;
    logic          result_valid;
    logic          result_ready;
    logic [RW-1:0] result;
    logic          result_error;
    logic          busy;

    int    errors = 0;
    int    checks = 0;
    string tag    = "init";

    typedef struct {
        logic [RW-1:0] ins;
        int            mulDly;   // cycles after the start cycle that mul_done pulses; <1 = never
        int            divDly;
        logic [RW-1:0] mulData;
        logic [RW-1:0] divData;
        int            hold;     // cycles result_ready stays low in RESP
        logic [RW-1:0] expRes;
        logic          expErr;
        int            expLat;   // cycles from the accept cycle to first result_valid
    } vec_t;

    execute_sequencer #(
        .OPERAND_WIDTH (OW),
        .RESULT_WIDTH  (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_operation(alu_operation),
        .alu_operand_1(alu_operand_1),
        .alu_operand_2(alu_operand_2),
        .alu_result   (alu_result),
        .mul_start    (mul_start),
        .mul_operand_1(mul_operand_1),
        .mul_operand_2(mul_operand_2),
        .mul_done     (mul_done),
        .mul_product  (mul_product),
        .div_start    (div_start),
        .div_operand_1(div_operand_1),
        .div_operand_2(div_operand_2),
        .div_done     (div_done),
        .div_result   (div_result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_error (result_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU seen by the sequencer.
    always_comb begin
        if (alu_operation) alu_result = RW'(alu_operand_1) - RW'(alu_operand_2);
        else               alu_result = RW'(alu_operand_1) + RW'(alu_operand_2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [RW-1:0] ins, input int mulDly, input int divDly,
                                input logic [RW-1:0] mulData, input logic [RW-1:0] divData,
                                input int hold, input logic [RW-1:0] expRes, input logic expErr,
                                input int expLat);
        vec_t v;
        v.ins = ins; v.mulDly = mulDly; v.divDly = divDly;
        v.mulData = mulData; v.divData = divData; v.hold = hold;
        v.expRes = expRes; v.expErr = expErr; v.expLat = expLat;
        return v;
    endfunction

    // Behavioural expectation straight from the instruction semantics.
    function automatic vec_t refModel(input vec_t v);
        vec_t r = v;
        int   a = int'(v.ins[15:8]);
        int   b = int'(v.ins[7:0]);
        int   dly;
        if (!v.ins[17]) begin
            r.expRes = v.ins[16] ? RW'(a - b) : RW'(a + b);
            r.expErr = 1'b0;
            r.expLat = 2;
        end else if (v.ins[16] && b == 0) begin
            r.expRes = 18'h3FFFF;
            r.expErr = 1'b1;
            r.expLat = 2;
        end else begin
            dly = v.ins[16] ? v.divDly : v.mulDly;
            if (dly >= 1 && dly <= TO) begin
                r.expRes = v.ins[16] ? v.divData : v.mulData;
                r.expErr = 1'b0;
                r.expLat = 2 + dly;
            end else begin
                r.expRes = '0;
                r.expErr = 1'b1;
                r.expLat = 2 + TO;
            end
        end
        return r;
    endfunction

    // Runs one instruction from an IDLE negedge back to an IDLE negedge.
    task automatic runOp(input vec_t v);
        int               t;
        int               mulCnt, divCnt, subCnt, mulAt, divAt, subAt;
        logic             readyBad, gotValid, holdBad, execBusy;
        logic [2*OW-1:0]  aluOps, mulOps, divOps;
        logic [RW-1:0]    heldRes;
        logic             heldErr;
        logic             isMul, isDiv, isSub;
        isMul = v.ins[17] && !v.ins[16];
        isDiv = v.ins[17] && v.ins[16] && (v.ins[7:0] != 8'd0);
        isSub = !v.ins[17] && v.ins[16];
        mulCnt = 0; divCnt = 0; subCnt = 0; mulAt = -1; divAt = -1; subAt = -1;
        readyBad = 1'b0; gotValid = 1'b0; holdBad = 1'b0; execBusy = 1'b0;
        aluOps = '0; mulOps = '0; divOps = '0;

        check("idle_ready", 32'(instr_ready), 32'd1);
        instr        = v.ins;
        instr_valid  = 1'b1;
        result_ready = (v.hold == 0);
        mul_product  = v.mulData;
        div_result   = v.divData;
        mul_done     = 1'b0;
        div_done     = 1'b0;
        t = 0;
        while (t < 2 * TO) begin
            @(posedge clk);
            @(negedge clk);
            t++;
            instr_valid = 1'b0;
            mul_done    = 1'b0;
            div_done    = 1'b0;
            if (mul_start)     begin mulCnt++; mulAt = t; end
            if (div_start)     begin divCnt++; divAt = t; end
            if (alu_operation) begin subCnt++; subAt = t; end
            if (t == 1) begin
                aluOps   = {alu_operand_1, alu_operand_2};
                mulOps   = {mul_operand_1, mul_operand_2};
                divOps   = {div_operand_1, div_operand_2};
                execBusy = busy;
            end
            if (instr_ready) readyBad = 1'b1;
            if (result_valid) begin
                gotValid = 1'b1;
                break;
            end
            mul_done = (v.mulDly > 0) && (t == 1 + v.mulDly);
            div_done = (v.divDly > 0) && (t == 1 + v.divDly);
        end
        mul_done = 1'b0;
        div_done = 1'b0;

        check("result_arrived", 32'(gotValid), 32'd1);
        if (gotValid) begin
            check("latency", 32'(t), 32'(v.expLat));
            check("result", 32'(result), 32'(v.expRes));
            check("error", 32'(result_error), 32'(v.expErr));
        end
        check("exec_busy", 32'(execBusy), 32'd1);
        check("ready_low", 32'(readyBad), 32'd0);
        check("mul_start_count", 32'(mulCnt), 32'(isMul));
        check("div_start_count", 32'(divCnt), 32'(isDiv));
        check("sub_count", 32'(subCnt), 32'(isSub));
        if (isMul) begin
            check("mul_start_at", 32'(mulAt), 32'd1);
            check("mul_operands", 32'(mulOps), 32'(v.ins[15:0]));
        end
        if (isDiv) begin
            check("div_start_at", 32'(divAt), 32'd1);
            check("div_operands", 32'(divOps), 32'(v.ins[15:0]));
        end
        if (isSub) check("sub_at", 32'(subAt), 32'd1);
        if (!v.ins[17]) check("alu_operands", 32'(aluOps), 32'(v.ins[15:0]));

        heldRes = result;
        heldErr = result_error;
        for (int h = 0; h < v.hold; h++) begin
            instr_valid  = 1'b1;
            instr        = ~v.ins;
            result_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (!result_valid || result !== heldRes || result_error !== heldErr || instr_ready)
                holdBad = 1'b1;
        end
        if (v.hold > 0) check("resp_hold", 32'(holdBad), 32'd0);
        instr_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_idle", 32'({result_valid, instr_ready, busy}), 32'b010);
    endtask

    function automatic int pickDelay();
        int sel = int'($urandom_range(0, 9));
        if (sel == 0) return -1;
        if (sel == 1) return TO;
        if (sel == 2) return TO + 1;
        return int'($urandom_range(1, 8));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[13];
        vec_t  v;
        logic  bad;
        logic  op, fn;
        logic [7:0] a, b;

        tbl[0]  = mk({2'b00, 8'd200, 8'd100}, -1, -1, 18'h0, 18'h0, 0, 18'd300, 1'b0, 2);
        tbl[1]  = mk({2'b01, 8'd50, 8'd20}, -1, -1, 18'h0, 18'h0, 0, 18'd30, 1'b0, 2);
        tbl[2]  = mk({2'b10, 8'd12, 8'd13}, 5, 2, 18'd156, 18'h1234, 0, 18'd156, 1'b0, 7);
        tbl[3]  = mk({2'b11, 8'd9, 8'd0}, -1, 1, 18'h0, 18'd5, 0, 18'h3FFFF, 1'b1, 2);
        tbl[4]  = mk({2'b11, 8'd100, 8'd7}, -1, -1, 18'h0, 18'd14, 0, 18'd0, 1'b1, 66);
        tbl[5]  = mk({2'b11, 8'd100, 8'd7}, -1, 64, 18'h0, 18'd14, 0, 18'd14, 1'b0, 66);
        tbl[6]  = mk({2'b11, 8'd100, 8'd7}, -1, 65, 18'h0, 18'd14, 0, 18'd0, 1'b1, 66);
        tbl[7]  = mk({2'b10, 8'd255, 8'd255}, 1, -1, 18'd65025, 18'h0, 0, 18'd65025, 1'b0, 3);
        tbl[8]  = mk({2'b10, 8'd2, 8'd3}, 63, -1, 18'd6, 18'h0, 0, 18'd6, 1'b0, 65);
        tbl[9]  = mk({2'b00, 8'd5, 8'd7}, -1, -1, 18'h0, 18'h0, 5, 18'd12, 1'b0, 2);
        tbl[10] = mk({2'b01, 8'd3, 8'd5}, -1, -1, 18'h0, 18'h0, 0, 18'h3FFFE, 1'b0, 2);
        tbl[11] = mk({2'b00, 8'd255, 8'd255}, -1, -1, 18'h0, 18'h0, 2, 18'd510, 1'b0, 2);
        tbl[12] = mk({2'b11, 8'd200, 8'd10}, 1, 3, 18'd999, 18'd20, 0, 18'd20, 1'b0, 5);

        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        mul_done     = 1'b0;
        div_done     = 1'b0;
        mul_product  = '0;
        div_result   = '0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tag = "reset";
        check("reset_flags", 32'({instr_ready, result_valid, busy, mul_start, div_start,
                                   result_error, alu_operation}), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_release_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            tag = $sformatf("vec%0d", i);
            runOp(tbl[i]);
        end

        // Reset while waiting on the multiplier, then a late mul_done.
        tag = "rst_wait";
        instr       = {2'b10, 8'd3, 8'd4};
        instr_valid = 1'b1;
        mul_product = 18'd12;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("wait_busy", 32'({busy, result_valid}), 32'b10);
        reset = 1'b1;
        #1;
        check("rst_gate", 32'({instr_ready, result_valid, busy}), 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_idle", 32'({instr_ready, busy, result_valid}), 32'b100);
        @(negedge clk);
        mul_done = 1'b1;
        @(posedge clk); @(negedge clk);
        mul_done = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (result_valid || busy || mul_start || !instr_ready) bad = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        check("late_done_ignored", 32'(bad), 32'd0);

        for (int i = 0; i < 40; i++) begin
            tag = $sformatf("rnd%0d", i);
            op = 1'($urandom_range(0, 1));
            fn = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            v.ins     = {op, fn, a, b};
            v.mulDly  = pickDelay();
            v.divDly  = pickDelay();
            v.mulData = 18'($urandom);
            v.divData = 18'($urandom);
            v.hold    = int'($urandom_range(0, 3));
            v = refModel(v);
            runOp(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
